// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and default widths for the cache line adaptor.
// Provides the adaptor FSM state type used by cacheline_adaptor.
package cache_types;

    localparam int unsigned DEFAULT_LINE_W = 256;
    localparam int unsigned DEFAULT_BEAT_W = 64;
    localparam int unsigned DEFAULT_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Bridges a single-transfer 256-bit cache line port to a 64-bit, 4-beat burst memory port.
// Optional watchdog: define LINE_ADAPTOR_TIMEOUT_EN to abort stalled bursts after TIMEOUT_CYC cycles.
module cacheline_adaptor
    import cache_types::*;
#(
    parameter int unsigned LINE_W      = DEFAULT_LINE_W,
    parameter int unsigned BEAT_W      = DEFAULT_BEAT_W,
    parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o,
    input  logic [ADDR_W-1:0] address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,
    input  logic [BEAT_W-1:0] burst_i,
    output logic [BEAT_W-1:0] burst_o,
    output logic [ADDR_W-1:0] address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i,
    output logic              timeout_o
);

    localparam int unsigned BEATS = LINE_W / BEAT_W;

    adaptor_state_t    state;
    logic [1:0]        beat;
    logic [LINE_W-1:0] wr_line;
    logic [ADDR_W-1:0] addr_q;
    logic              busy;
    logic              last_beat;
    logic              timeout_hit;
    logic              unused_bits;

    assign busy      = (state == RD) || (state == WR);
    assign last_beat = (beat == 2'(BEATS - 1));

    // Outputs decode straight from state so an async reset drops read_o/write_o immediately.
    assign read_o    = (state == RD);
    assign write_o   = (state == WR);
    assign resp_o    = (state == DONE);
    assign address_o = addr_q;
    assign burst_o   = wr_line[beat*BEAT_W +: BEAT_W];

    assign unused_bits = ^{address_i[4:0], (TIMEOUT_CYC == 0)};

`ifdef LINE_ADAPTOR_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] wd_cnt;
    logic             timeout_q;

    assign timeout_hit = busy && !resp_i && (wd_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign timeout_o   = timeout_q;

    // Counts stalled cycles only; any accepted beat restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (busy && !resp_i && !timeout_hit)
                wd_cnt <= wd_cnt + TMO_W'(1);
            else
                wd_cnt <= '0;
            if (timeout_hit)
                timeout_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            beat    <= '0;
            wr_line <= '0;
            addr_q  <= '0;
            line_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    beat <= '0;
                    if (write_i) begin
                        wr_line <= line_i;
                        addr_q  <= {address_i[ADDR_W-1:5], 5'b0};
                        state   <= WR;
                    end else if (read_i) begin
                        addr_q  <= {address_i[ADDR_W-1:5], 5'b0};
                        state   <= RD;
                    end
                end
                RD, WR: begin
                    if (resp_i) begin
                        if (state == RD)
                            line_o[beat*BEAT_W +: BEAT_W] <= burst_i;
                        beat <= last_beat ? 2'd0 : beat + 2'd1;
                        if (last_beat)
                            state <= DONE;
                    end else if (timeout_hit) begin
                        beat  <= '0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor (default build, watchdog disabled).
// Memory side is modelled as a list of beats consumed/produced in order on resp_i cycles.
module tb_cacheline_adaptor;

    localparam int unsigned LW = 256;
    localparam int unsigned BW = 64;
    localparam int unsigned AW = 32;
    localparam logic [31:0] ALIGN = 32'hFFFF_FFE0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [LW-1:0] line_i;
    logic [LW-1:0] line_o;
    logic [AW-1:0] address_i;
    logic          read_i;
    logic          write_i;
    logic          resp_o;
    logic [BW-1:0] burst_i;
    logic [BW-1:0] burst_o;
    logic [AW-1:0] address_o;
    logic          read_o;
    logic          write_o;
    logic          resp_i;
    logic          timeout_o;

    int errors = 0;
    int checks = 0;
    logic [LW-1:0] last_rd = '0;

    always #5 clk = ~clk;

    cacheline_adaptor #(
        .LINE_W(LW),
        .BEAT_W(BW),
        .ADDR_W(AW),
        .TIMEOUT_CYC(1024)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .line_i(line_i),
        .line_o(line_o),
        .address_i(address_i),
        .read_i(read_i),
        .write_i(write_i),
        .resp_o(resp_o),
        .burst_i(burst_i),
        .burst_o(burst_o),
        .address_o(address_o),
        .read_o(read_o),
        .write_o(write_o),
        .resp_i(resp_i),
        .timeout_o(timeout_o)
    );

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Presents a request for one edge, then scrambles the inputs the adaptor should have latched.
    task automatic start_req(input bit rd, input bit wr, input logic [31:0] addr, input logic [LW-1:0] line);
        address_i = addr;
        line_i    = line;
        read_i    = rd;
        write_i   = wr;
        @(negedge clk);
        read_i    = 1'b0;
        write_i   = 1'b0;
        address_i = $urandom;
        line_i    = rand_line();
    endtask

    // Serves one burst; mode 0 back-to-back, 1 fixed gap pattern, 2 random gaps.
    task automatic run_burst(input bit is_wr, input logic [31:0] exp_addr, input logic [LW-1:0] wline,
                             input logic [LW-1:0] rdata, input int mode, output int active);
        bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int nb = 0;
        bit r;
        active = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (resp_o === 1'b1) break;
            checks++;
            if (nb >= 4) begin
                errors++;
                $display("FAIL extra_beat_cycle: resp_o=%b after %0d beats, required 1", resp_o, nb);
                break;
            end
            checks++;
            if (read_o !== !is_wr || write_o !== is_wr) begin
                errors++;
                $display("FAIL burst_ctrl: read_o=%b write_o=%b, required %b %b", read_o, write_o, !is_wr, is_wr);
            end
            checks++;
            if (address_o !== exp_addr) begin
                errors++;
                $display("FAIL burst_addr: address_o=%h, required %h", address_o, exp_addr);
            end
            active++;
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc < 7) ? pat[cyc] : 1'b1;
                default: r = 1'($urandom_range(0, 1));
            endcase
            resp_i = r;
            if (r) begin
                burst_i = rdata[nb*BW +: BW];
                if (is_wr) begin
                    checks++;
                    if (burst_o !== wline[nb*BW +: BW]) begin
                        errors++;
                        $display("FAIL wr_beat%0d: burst_o=%h, required %h", nb, burst_o, wline[nb*BW +: BW]);
                    end
                end
                nb++;
            end else begin
                burst_i = {$urandom, $urandom};
            end
            @(negedge clk);
        end
        // resp_i is asserted in DONE to show it is ignored there.
        resp_i  = 1'b1;
        burst_i = {$urandom, $urandom};
        checks++;
        if (resp_o !== 1'b1 || nb != 4) begin
            errors++;
            $display("FAIL done_resp: resp_o=%b beats=%0d, required 1 and 4", resp_o, nb);
        end
        if (!is_wr) begin
            checks++;
            if (line_o !== rdata) begin
                errors++;
                $display("FAIL read_line: line_o=%h, required %h", line_o, rdata);
            end
        end
        checks++;
        if (read_o !== 1'b0 || write_o !== 1'b0) begin
            errors++;
            $display("FAIL done_ctrl: read_o=%b write_o=%b, required 0 0", read_o, write_o);
        end
        @(negedge clk);
        resp_i = 1'b0;
        checks++;
        if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0) begin
            errors++;
            $display("FAIL resp_pulse: resp_o=%b read_o=%b write_o=%b, required 0 0 0", resp_o, read_o, write_o);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0 || timeout_o !== 1'b0 ||
            address_o !== '0 || burst_o !== '0 || line_o !== '0) begin
            errors++;
            $display("FAIL reset_state: rd=%b wr=%b resp=%b to=%b addr=%h burst=%h line_nz=%b, required all 0",
                     read_o, write_o, resp_o, timeout_o, address_o, burst_o, |line_o);
        end
    endtask

    task automatic test_read();
        logic [LW-1:0] d;
        int act;
        d = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        start_req(1'b1, 1'b0, 32'h0000_1234, rand_line());
        run_burst(1'b0, 32'h0000_1220, '0, d, 0, act);
        checks++;
        if (act != 4) begin
            errors++;
            $display("FAIL read_cycles: read_o high %0d cycles, required 4", act);
        end
        last_rd = d;
    endtask

    task automatic test_write();
        logic [LW-1:0] w;
        int act;
        w = 256'h0123456789abcdef_fedcba9876543210_0011223344556677_8899aabbccddeeff;
        start_req(1'b0, 1'b1, 32'h8000_0040, w);
        run_burst(1'b1, 32'h8000_0040, w, rand_line(), 0, act);
        checks++;
        if (act != 4) begin
            errors++;
            $display("FAIL write_cycles: write_o high %0d cycles, required 4", act);
        end
        checks++;
        if (line_o !== last_rd) begin
            errors++;
            $display("FAIL line_hold: line_o=%h, required %h", line_o, last_rd);
        end
    endtask

    task automatic test_gapped();
        logic [LW-1:0] d;
        logic [31:0]   a;
        int act;
        d = rand_line();
        a = $urandom;
        start_req(1'b1, 1'b0, a, rand_line());
        run_burst(1'b0, a & ALIGN, '0, d, 1, act);
        last_rd = d;
        a = $urandom;
        d = rand_line();
        start_req(1'b0, 1'b1, a, d);
        run_burst(1'b1, a & ALIGN, d, rand_line(), 1, act);
    endtask

    task automatic test_both_and_hold();
        logic [LW-1:0] w;
        logic [LW-1:0] d;
        int act;
        w = rand_line();
        start_req(1'b1, 1'b1, 32'h0000_0a5f, w);
        run_burst(1'b1, 32'h0000_0a40, w, rand_line(), 0, act);
        // read_i stays high across the whole transfer and through DONE
        d = rand_line();
        address_i = 32'h1234_5678;
        read_i    = 1'b1;
        @(negedge clk);
        run_burst(1'b0, 32'h1234_5660, '0, d, 2, act);
        last_rd = d;
        @(negedge clk);
        checks++;
        if (read_o !== 1'b1 || address_o !== 32'h1234_5660) begin
            errors++;
            $display("FAIL held_read_accept: read_o=%b addr=%h, required 1 12345660", read_o, address_o);
        end
        read_i = 1'b0;
        d = rand_line();
        run_burst(1'b0, 32'h1234_5660, '0, d, 0, act);
        last_rd = d;
    endtask

    task automatic test_idle_noise();
        for (int i = 0; i < 3; i++) begin
            resp_i  = 1'b1;
            burst_i = {$urandom, $urandom};
            @(negedge clk);
            checks++;
            if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0 || line_o !== last_rd) begin
                errors++;
                $display("FAIL idle_noise: rd=%b wr=%b resp=%b line_changed=%b, required 0 0 0 0",
                         read_o, write_o, resp_o, line_o !== last_rd);
            end
        end
        resp_i = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        logic [LW-1:0] d;
        int act;
        start_req(1'b1, 1'b0, 32'h0000_2000, rand_line());
        for (int i = 0; i < 2; i++) begin
            resp_i  = 1'b1;
            burst_i = {$urandom, $urandom};
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (read_o !== 1'b0 || resp_o !== 1'b0 || line_o !== '0) begin
            errors++;
            $display("FAIL reset_mid_burst: read_o=%b resp_o=%b line_nz=%b, required 0 0 0", read_o, resp_o, |line_o);
        end
        resp_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (read_o !== 1'b0 || resp_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: read_o=%b resp_o=%b, required 0 0", read_o, resp_o);
        end
        last_rd = '0;
        d = rand_line();
        start_req(1'b1, 1'b0, 32'h0000_2004, rand_line());
        run_burst(1'b0, 32'h0000_2000, '0, d, 0, act);
        last_rd = d;
    endtask

    task automatic test_random();
        bit            is_wr;
        logic [31:0]   a;
        logic [LW-1:0] l;
        int act;
        for (int t = 0; t < 20; t++) begin
            is_wr = 1'($urandom_range(0, 1));
            a     = $urandom;
            l     = rand_line();
            start_req(!is_wr, is_wr, a, l);
            run_burst(is_wr, a & ALIGN, l, l, 2, act);
            if (!is_wr) begin
                last_rd = l;
            end else begin
                checks++;
                if (line_o !== last_rd) begin
                    errors++;
                    $display("FAIL rand_line_hold: line_o=%h, required %h", line_o, last_rd);
                end
            end
        end
        checks++;
        if (timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_tied: timeout_o=%b, required 0", timeout_o);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_read();
        test_write();
        test_gapped();
        test_both_and_hold();
        test_idle_noise();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
